// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl
// Description : Pipeline stall/flush controller for load-use, multi-cycle
//               MDU and memory-wait hazards, with a saturating stall counter.
// Revision    : 1.0
// ============================================================================
module pipe_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic        ex_valid,
    input  logic [4:0]  ex_rd,
    input  logic        ex_is_load,
    input  logic        ex_mdu_start,
    input  logic        mdu_done,
    input  logic        mem_req,
    input  logic        mem_ready,
    input  logic        ex_redirect,
    output logic        if_ena,
    output logic        id_ena,
    output logic        ex_ena,
    output logic        id_flush,
    output logic        ex_bubble,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MDU_WAIT = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    localparam logic [31:0] C_CNT_MAX = 32'hFFFF_FFFF;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_stall_cnt;

    logic w_load_use;
    logic w_mem_stall;
    logic w_mdu_go;
    logic w_if_ena;
    logic w_id_ena;
    logic w_ex_ena;
    logic w_id_flush;
    logic w_ex_bubble;

    assign w_load_use  = ex_valid & ex_is_load & (ex_rd != 5'd0) &
                         ((id_use_rs1 & (id_rs1 == ex_rd)) |
                          (id_use_rs2 & (id_rs2 == ex_rd)));
    assign w_mem_stall = mem_req & ~mem_ready;
    assign w_mdu_go    = ex_valid & ex_mdu_start;

    always_comb begin
        w_if_ena     = 1'b0;
        w_id_ena     = 1'b0;
        w_ex_ena     = 1'b0;
        w_id_flush   = 1'b0;
        w_ex_bubble  = 1'b0;
        w_next_state = ST_RUN;
        case (r_state)
            ST_MDU_WAIT: begin
                w_next_state = ST_MDU_WAIT;
                if (mdu_done) begin
                    if (w_mem_stall) begin
                        w_next_state = ST_MEM_WAIT;
                    end else begin
                        w_if_ena     = 1'b1;
                        w_id_ena     = 1'b1;
                        w_ex_ena     = 1'b1;
                        w_next_state = ST_RUN;
                    end
                end
            end
            ST_MEM_WAIT: begin
                w_next_state = ST_MEM_WAIT;
                if (mem_ready) begin
                    w_if_ena     = 1'b1;
                    w_id_ena     = 1'b1;
                    w_ex_ena     = 1'b1;
                    w_next_state = ST_RUN;
                end
            end
            // RUN, and the unused encoding 3 which recovers into RUN
            default: begin
                if (w_mem_stall) begin
                    w_next_state = ST_MEM_WAIT;
                end else if (w_mdu_go) begin
                    w_next_state = ST_MDU_WAIT;
                end else if (ex_redirect) begin
                    w_if_ena    = 1'b1;
                    w_id_ena    = 1'b1;
                    w_ex_ena    = 1'b1;
                    w_id_flush  = 1'b1;
                    w_ex_bubble = 1'b1;
                end else if (w_load_use) begin
                    w_ex_ena    = 1'b1;
                    w_ex_bubble = 1'b1;
                end else begin
                    w_if_ena = 1'b1;
                    w_id_ena = 1'b1;
                    w_ex_ena = 1'b1;
                end
            end
        endcase
        if (!rst) begin
            w_if_ena     = 1'b0;
            w_id_ena     = 1'b0;
            w_ex_ena     = 1'b0;
            w_id_flush   = 1'b0;
            w_ex_bubble  = 1'b0;
            w_next_state = ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_RUN;
            r_stall_cnt <= 32'd0;
        end else begin
            r_state <= w_next_state;
            if (!w_if_ena && (r_stall_cnt != C_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign if_ena    = w_if_ena;
    assign id_ena    = w_id_ena;
    assign ex_ena    = w_ex_ena;
    assign id_flush  = w_id_flush;
    assign ex_bubble = w_ex_bubble;
    assign state     = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk (rising edge) and rst (low = reset, sampled only on the clk rising edge).
REQ-002 Port list (name, direction, width, meaning) SHALL be as follows.
- clk, in, 1: clock.
- rst, in, 1: synchronous active-low reset.
- id_rs1, in, 5: ID-stage source register 1.
- id_rs2, in, 5: ID-stage source register 2.
- id_use_rs1, in, 1: ID instruction reads rs1.
- id_use_rs2, in, 1: ID instruction reads rs2.
- ex_valid, in, 1: EX stage holds a real instruction.
- ex_rd, in, 5: EX destination register.
- ex_is_load, in, 1: EX instruction is a load.
- ex_mdu_start, in, 1: EX instruction is a multi-cycle mul/div.
- mdu_done, in, 1: multiply/divide unit result ready.
- mem_req, in, 1: memory access issued this cycle.
- mem_ready, in, 1: memory completes the access this cycle.
- ex_redirect, in, 1: taken branch/jump resolved in EX.
- if_ena, out, 1: PC/IF register enable.
- id_ena, out, 1: ID register enable.
- ex_ena, out, 1: EX register enable.
- id_flush, out, 1: ID register loads NOP on its next enabled edge.
- ex_bubble, out, 1: EX register loads NOP (inst 0, mem_wen/mem_ena 0) on its next enabled edge.
- state, out, 2: 0 = RUN, 1 = MDU_WAIT, 2 = MEM_WAIT.
- stall_cnt, out, 32: saturating count of stall cycles.
REQ-003 All control outputs SHALL be combinational functions of state, rst and the inputs. state and stall_cnt SHALL be registers.

Function
REQ-004 Hazard terms:
- load_use = ex_valid & ex_is_load & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
- mem_stall = mem_req & ~mem_ready.
- mdu_go = ex_valid & ex_mdu_start.
REQ-005 In RUN, decisions SHALL be taken in this priority order: mem_stall, then mdu_go, then ex_redirect, then load_use, then normal.
REQ-006 In RUN with mem_stall: if_ena = id_ena = ex_ena = 0; next state MEM_WAIT.
REQ-007 In RUN with mdu_go (and no mem_stall): all enables 0; next state MDU_WAIT.
REQ-008 In RUN with ex_redirect only: all enables 1, id_flush = 1, ex_bubble = 1; state stays RUN; any load_use in the same cycle SHALL be ignored.
REQ-009 In RUN with load_use only: if_ena = id_ena = 0, ex_ena = 1, ex_bubble = 1. Exactly one bubble is inserted per load-use pair.
REQ-010 In RUN with no event: all enables 1, id_flush = 0, ex_bubble = 0.
REQ-011 MEM_WAIT behaviour:
- While mem_ready = 0: all enables 0.
- When mem_ready = 1: all enables 1 in that same cycle and next state RUN.
- ex_redirect and load_use SHALL be ignored while in MEM_WAIT.
REQ-012 MDU_WAIT behaviour:
- While mdu_done = 0: all enables 0.
- When mdu_done = 1: all enables 1 in that same cycle and next state RUN.
- If mem_stall is also asserted in that cycle: all enables stay 0 and next state is MEM_WAIT.
REQ-013 In MEM_WAIT and MDU_WAIT, id_flush and ex_bubble SHALL be 0.
REQ-014 stall_cnt SHALL increment by 1 on every edge where if_ena = 0 and rst = 1, and SHALL saturate at 0xFFFFFFFF.
REQ-015 State encoding 3 SHALL be unreachable; if it is ever entered, the block SHALL behave as RUN and move to RUN on the next edge.
REQ-016 No control output SHALL depend on its own value through a combinational loop.

Reset
REQ-017 While rst = 0: if_ena = id_ena = ex_ena = 0 and id_flush = ex_bubble = 0.
REQ-018 On an edge with rst = 0: state <= RUN and stall_cnt <= 0.
REQ-019 Reset asserted in MDU_WAIT or MEM_WAIT SHALL abandon the wait. After rst returns high, operation resumes in RUN with no residual stall.

Verification
REQ-020 Load-use: ex_valid = 1, ex_is_load = 1, ex_rd = 5; id_rs2 = 5, id_use_rs2 = 1 -> if_ena = 0, id_ena = 0, ex_ena = 1, ex_bubble = 1 for exactly 1 cycle; stall_cnt +1. Repeating with ex_rd = 0 -> no stall.
REQ-021 MDU: ex_mdu_start pulse, then mdu_done after 7 cycles -> state = 1 for 7 cycles with all enables 0; enables 1 on the mdu_done cycle; then state = 0; stall_cnt increases by 7 (1 cycle in RUN plus 6 waiting, mdu_done cycle not counted).
REQ-022 Memory wait: mem_req = 1, mem_ready = 0 for 3 cycles, then 1 -> state = 2 from the second cycle; enables 0 for 3 cycles; enables 1 on the ready cycle.
REQ-023 Redirect with simultaneous load_use -> id_flush = 1, ex_bubble = 1, all enables 1, no stall counted.
REQ-024 rst driven low mid-MDU_WAIT for 1 edge -> state = 0, stall_cnt = 0; enables = 0 while rst is low, then = 1 on the first cycle after release with no hazard.
REQ-025 Preload stall_cnt near 0xFFFFFFFF via a long stall -> counter holds at 0xFFFFFFFF and does not wrap.
